// File: rtl/pong_pkg.sv
// Shared types for the paddle controller: paddle modes, FSM states and
// the extra headroom bits used by the target arithmetic.
package pong_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'b00,
        TRACK   = 2'b01,
        PREDICT = 2'b10,
        CENTER  = 2'b11
    } paddle_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LATCH = 2'b01,
        CALC  = 2'b10,
        DONE  = 2'b11
    } ctrl_state_t;

    // Signed headroom so ball_y + ball_vy*LOOKAHEAD never wraps.
    localparam int EXT_W = 6;

endpackage

// File: rtl/paddle_step.sv
// Combinational single-paddle update: pick a target from the mode, clamp it,
// apply the deadband and step limit, then clamp the new centre to the screen.
module paddle_step
    import pong_pkg::*;
#(
    parameter int COORD_W            = 16,
    parameter int HALF_PADDLE_HEIGHT = 50,
    parameter int SCREEN_HEIGHT      = 480,
    parameter int MAX_STEP           = 5,
    parameter int DEADBAND           = 4,
    parameter int LOOKAHEAD          = 8
) (
    input  paddle_mode_t       mode_i,
    input  logic [COORD_W-1:0] ball_y_i,
    input  logic [COORD_W-1:0] ball_vy_i,
    input  logic [COORD_W-1:0] center_i,
    output logic [COORD_W-1:0] center_o
);

    localparam int AW = COORD_W + EXT_W;
    typedef logic signed [AW-1:0] arith_t;

    localparam arith_t SCREEN_MAX = arith_t'(SCREEN_HEIGHT - 1);
    localparam arith_t SCREEN_MID = arith_t'(SCREEN_HEIGHT / 2);
    localparam arith_t CENTER_LO  = arith_t'(HALF_PADDLE_HEIGHT);
    localparam arith_t CENTER_HI  = arith_t'(SCREEN_HEIGHT - 1 - HALF_PADDLE_HEIGHT);
    localparam arith_t STEP_MAX   = arith_t'(MAX_STEP);
    localparam arith_t DEAD       = arith_t'(DEADBAND);
    localparam arith_t LOOK       = arith_t'(LOOKAHEAD);

    arith_t ball_y_s, ball_vy_s, center_s;
    arith_t predicted, target, diff, magnitude, step, moved;

    always_comb begin
        // NOTE: every combinational variable gets a default first so no path
        // through the case/if tree can leave it unassigned and infer a latch.
        ball_y_s  = {{EXT_W{1'b0}}, ball_y_i};
        ball_vy_s = {{EXT_W{ball_vy_i[COORD_W-1]}}, ball_vy_i};
        center_s  = {{EXT_W{1'b0}}, center_i};
        target    = center_s;
        step      = '0;
        moved     = center_s;

        predicted = ball_y_s + ball_vy_s * LOOK;
        if (predicted < 0)               predicted = '0;
        else if (predicted > SCREEN_MAX) predicted = SCREEN_MAX;

        case (mode_i)
            HOLD:    target = center_s;
            TRACK:   target = ball_y_s;
            PREDICT: target = predicted;
            CENTER:  target = SCREEN_MID;
            default: target = center_s;
        endcase

        diff      = target - center_s;
        magnitude = (diff < 0) ? -diff : diff;

        if (magnitude > DEAD) begin
            step  = (magnitude > STEP_MAX) ? STEP_MAX : magnitude;
            moved = (diff < 0) ? center_s - step : center_s + step;
        end

        if (moved < CENTER_LO)      moved = CENTER_LO;
        else if (moved > CENTER_HI) moved = CENTER_HI;

        center_o = moved[COORD_W-1:0];
    end

endmodule

// File: rtl/paddle_controller.sv
// Frame-driven paddle controller: latches the ball state on frame_tick and
// updates one paddle per cycle through a single shared paddle_step.
module paddle_controller
    import pong_pkg::*;
#(
    parameter int COORD_W            = 16,
    parameter int NUM_PADDLES        = 2,
    parameter int HALF_PADDLE_HEIGHT = 50,
    parameter int SCREEN_HEIGHT      = 480,
    parameter int MAX_STEP           = 5,
    parameter int DEADBAND           = 4,
    parameter int LOOKAHEAD          = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_tick,
    input  logic [COORD_W-1:0]             ball_y,
    input  logic [COORD_W-1:0]             ball_vy,
    input  logic [2*NUM_PADDLES-1:0]       mode,
    output logic [COORD_W*NUM_PADDLES-1:0] paddle_y,
    output logic                           busy,
    output logic                           update_done,
    output logic                           overrun
);

    localparam int K_W = (NUM_PADDLES > 1) ? $clog2(NUM_PADDLES) : 1;
    localparam logic [K_W-1:0]     K_LAST   = K_W'(NUM_PADDLES - 1);
    localparam logic [COORD_W-1:0] MID_Y    = COORD_W'(SCREEN_HEIGHT / 2);

    ctrl_state_t                state_q;
    logic [K_W-1:0]             k_q;
    logic [COORD_W-1:0]         paddle_q [NUM_PADDLES];
    logic [COORD_W-1:0]         ball_y_q, ball_vy_q;
    logic [2*NUM_PADDLES-1:0]   mode_q;
    logic                       busy_q, done_q, overrun_q;
    logic [COORD_W-1:0]         step_center;
    paddle_mode_t               step_mode;

    assign step_mode = paddle_mode_t'(mode_q[2*k_q +: 2]);

    paddle_step #(
        .COORD_W           (COORD_W),
        .HALF_PADDLE_HEIGHT(HALF_PADDLE_HEIGHT),
        .SCREEN_HEIGHT     (SCREEN_HEIGHT),
        .MAX_STEP          (MAX_STEP),
        .DEADBAND          (DEADBAND),
        .LOOKAHEAD         (LOOKAHEAD)
    ) u_step (
        .mode_i   (step_mode),
        .ball_y_i (ball_y_q),
        .ball_vy_i(ball_vy_q),
        .center_i (paddle_q[k_q]),
        .center_o (step_center)
    );

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            ball_y_q  <= '0;
            ball_vy_q <= '0;
            mode_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            // NOTE: the paddle array is a handful of flops, not a RAM, so it is
            // reset; an aborted update must leave no half-moved paddle behind.
            for (int i = 0; i < NUM_PADDLES; i++) paddle_q[i] <= MID_Y;
        end else begin
            if (frame_tick && state_q != IDLE) overrun_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (frame_tick) begin
                        state_q <= LATCH;
                        busy_q  <= 1'b1;
                    end
                end
                LATCH: begin
                    ball_y_q  <= ball_y;
                    ball_vy_q <= ball_vy;
                    mode_q    <= mode;
                    k_q       <= '0;
                    state_q   <= CALC;
                end
                CALC: begin
                    paddle_q[k_q] <= step_center;
                    if (k_q == K_LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_out
        assign paddle_y[i*COORD_W +: COORD_W] = paddle_q[i];
    end

    assign busy        = busy_q;
    assign update_done = done_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_paddle_controller.sv
// Directed bench for paddle_controller at default parameters (two paddles,
// 480-line screen); expected values are hand-computed per scenario.
module tb_paddle_controller;

    localparam int W = 16;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           frame_tick = 1'b0;
    logic [W-1:0]   ball_y = '0;
    logic [W-1:0]   ball_vy = '0;
    logic [2*N-1:0] mode = '0;
    logic [W*N-1:0] paddle_y;
    logic           busy, update_done, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    paddle_controller dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .ball_y     (ball_y),
        .ball_vy    (ball_vy),
        .mode       (mode),
        .paddle_y   (paddle_y),
        .busy       (busy),
        .update_done(update_done),
        .overrun    (overrun)
    );

    function automatic int py(int i);
        return int'(paddle_y[i*W +: W]);
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        frame_tick = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Waits two negedges (so the previous DONE cycle is over), pulses
    // frame_tick for one cycle and returns #1 after the edge that raises
    // update_done. lat counts edges after the sampling edge; the DONE cycle
    // is tick cycle + 4, i.e. 3 edges later. lat = -1 when the budget expires.
    task automatic tick_and_wait(output int lat);
        lat = -1;
        repeat (2) @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        @(negedge clk);
        frame_tick = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (update_done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (py(0) !== 240 || py(1) !== 240) begin n_bad++;
            $display("FAIL reset_hold_paddles: got %0d/%0d want 240/240", py(0), py(1)); end
        n_cmp++; if ({busy, update_done, overrun} !== 3'b000) begin n_bad++;
            $display("FAIL reset_hold_flags: got %b want 000", {busy, update_done, overrun}); end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (py(0) !== 240 || py(1) !== 240) begin n_bad++;
            $display("FAIL reset_release_paddles: got %0d/%0d want 240/240", py(0), py(1)); end
        n_cmp++; if ({busy, update_done, overrun} !== 3'b000) begin n_bad++;
            $display("FAIL reset_release_flags: got %b want 000", {busy, update_done, overrun}); end
    endtask

    task automatic test_track();
        int lat, exp_y;
        ball_y = 16'd300;
        ball_vy = '0;
        mode = 4'b0101;
        for (int t = 1; t <= 14; t++) begin
            tick_and_wait(lat);
            exp_y = (240 + 5*t > 300) ? 300 : 240 + 5*t;
            n_cmp++; if (lat !== 3) begin n_bad++;
                $display("FAIL track_latency tick %0d: got %0d edges want 3", t, lat); end
            n_cmp++; if (py(0) !== exp_y || py(1) !== exp_y) begin n_bad++;
                $display("FAIL track_pos tick %0d: got %0d/%0d want %0d", t, py(0), py(1), exp_y); end
        end
        @(posedge clk); #1;
        n_cmp++; if (update_done !== 1'b0 || busy !== 1'b0) begin n_bad++;
            $display("FAIL track_done_pulse: done=%b busy=%b want 0/0", update_done, busy); end
    endtask

    task automatic test_deadband();
        int lat;
        apply_reset();
        ball_y = 16'd243;
        mode = 4'b0101;
        for (int t = 1; t <= 10; t++) begin
            tick_and_wait(lat);
            n_cmp++; if (py(0) !== 240 || py(1) !== 240) begin n_bad++;
                $display("FAIL deadband tick %0d: got %0d/%0d want 240", t, py(0), py(1)); end
        end
    endtask

    task automatic test_clamp();
        int lat, lo, hi;
        lo = 240; hi = 240;
        ball_y = 16'd5;
        mode = 4'b0101;
        for (int t = 1; t <= 60; t++) begin
            tick_and_wait(lat);
            if (py(0) < lo) lo = py(0);
            if (py(1) < lo) lo = py(1);
        end
        n_cmp++; if (lo !== 50) begin n_bad++;
            $display("FAIL clamp_low_min: got %0d want 50", lo); end
        n_cmp++; if (py(0) !== 50 || py(1) !== 50) begin n_bad++;
            $display("FAIL clamp_low_final: got %0d/%0d want 50", py(0), py(1)); end
        ball_y = 16'd479;
        for (int t = 1; t <= 80; t++) begin
            tick_and_wait(lat);
            if (py(0) > hi) hi = py(0);
            if (py(1) > hi) hi = py(1);
        end
        n_cmp++; if (hi !== 429) begin n_bad++;
            $display("FAIL clamp_high_max: got %0d want 429", hi); end
        n_cmp++; if (py(0) !== 429 || py(1) !== 429) begin n_bad++;
            $display("FAIL clamp_high_final: got %0d/%0d want 429", py(0), py(1)); end
    endtask

    task automatic test_mixed();
        int lat, exp_y;
        apply_reset();
        ball_y = 16'd400;
        ball_vy = 16'hFFF6;          // -10
        mode = 4'b0010;              // paddle1 HOLD, paddle0 PREDICT
        for (int t = 1; t <= 19; t++) begin
            tick_and_wait(lat);
            exp_y = (240 + 5*t > 320) ? 320 : 240 + 5*t;
            n_cmp++; if (py(0) !== exp_y) begin n_bad++;
                $display("FAIL mixed_predict tick %0d: got %0d want %0d", t, py(0), exp_y); end
            n_cmp++; if (py(1) !== 240) begin n_bad++;
                $display("FAIL mixed_hold tick %0d: got %0d want 240", t, py(1)); end
        end
        ball_vy = '0;
    endtask

    task automatic test_input_latch();
        bit seen;
        apply_reset();
        ball_y = 16'd300;
        mode = 4'b0101;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(posedge clk);                  // LATCH -> CALC, inputs captured
        @(negedge clk);
        ball_y = 16'd0;
        mode = 4'b0000;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(posedge clk); #1;
            if (update_done) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b1) begin n_bad++;
            $display("FAIL latch_done_timeout: got done=%b want 1", seen); end
        n_cmp++; if (py(0) !== 245 || py(1) !== 245) begin n_bad++;
            $display("FAIL latch_inputs: got %0d/%0d want 245/245", py(0), py(1)); end
    endtask

    task automatic test_overrun();
        int dones, lat;
        apply_reset();
        ball_y = 16'd300;
        mode = 4'b0101;
        n_cmp++; if (overrun !== 1'b0) begin n_bad++;
            $display("FAIL overrun_init: got %b want 0", overrun); end
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        @(negedge clk); frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        dones = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (update_done) dones++;
        end
        n_cmp++; if (dones !== 1) begin n_bad++;
            $display("FAIL overrun_single_update: got %0d pulses want 1", dones); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++;
            $display("FAIL overrun_set: got %b want 1", overrun); end
        n_cmp++; if (py(0) !== 245) begin n_bad++;
            $display("FAIL overrun_one_step: got %0d want 245", py(0)); end
        tick_and_wait(lat);
        n_cmp++; if (overrun !== 1'b1) begin n_bad++;
            $display("FAIL overrun_sticky: got %b want 1", overrun); end

        apply_reset();
        n_cmp++; if (overrun !== 1'b0) begin n_bad++;
            $display("FAIL overrun_cleared: got %b want 0", overrun); end
        tick_and_wait(lat);
        @(negedge clk); frame_tick = 1'b1;   // still the DONE cycle
        @(negedge clk); frame_tick = 1'b0;
        dones = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk); #1;
            if (update_done) dones++;
        end
        n_cmp++; if (overrun !== 1'b1 || dones !== 0) begin n_bad++;
            $display("FAIL overrun_done_cycle: got ovr=%b pulses=%0d want 1/0", overrun, dones); end
    endtask

    task automatic test_abort();
        int dones;
        apply_reset();
        ball_y = 16'd300;
        mode = 4'b0101;
        @(negedge clk); frame_tick = 1'b1;
        @(posedge clk);                      // tick sampled
        @(negedge clk); frame_tick = 1'b0;
        @(posedge clk);                      // LATCH -> CALC
        @(posedge clk); #1;                  // paddle 0 written
        n_cmp++; if (py(0) !== 245 || py(1) !== 240 || busy !== 1'b1) begin n_bad++;
            $display("FAIL abort_partial: got %0d/%0d busy=%b want 245/240 busy=1", py(0), py(1), busy); end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (py(0) !== 240 || py(1) !== 240) begin n_bad++;
            $display("FAIL abort_paddles: got %0d/%0d want 240/240", py(0), py(1)); end
        n_cmp++; if ({busy, update_done, overrun} !== 3'b000) begin n_bad++;
            $display("FAIL abort_flags: got %b want 000", {busy, update_done, overrun}); end
        @(negedge clk); rst = 1'b1;
        dones = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (update_done || busy) dones++;
        end
        n_cmp++; if (dones !== 0 || py(0) !== 240) begin n_bad++;
            $display("FAIL abort_stays_idle: got activity=%0d y=%0d want 0/240", dones, py(0)); end
    endtask

    initial begin
        test_reset();
        test_track();
        test_deadband();
        test_clamp();
        test_mixed();
        test_input_latch();
        test_overrun();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
